fpu_cmd_sequencer: RTL and testbench

- Request front-end that sits directly upstream of the FPU datapath (clk, start, ALU_Control, a, b -> result_out, done).
- Accepts operation requests on a valid/ready interface and buffers them in a small FIFO.
- Issues one request at a time to the datapath as a one-cycle start pulse, with operands held stable until the datapath signals done.
- Returns each result, its tag and an error flag on a valid/ready response interface.

---
 rtl/fpu_pkg.sv | 23 ++
 rtl/fpu_cmd_fifo.sv | 53 +++++
 rtl/fpu_cmd_sequencer.sv | 164 ++++++++++++++++
 tb/tb_fpu_cmd_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types for the FPU command sequencer: sizes, FSM encoding and the
// request payload carried through the command FIFO.
package fpu_pkg;

    localparam int OP_W   = 2;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // The tag width is a parameter of the top, so the tag is stored next to
    // this struct inside each FIFO entry rather than as a field of it.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } req_t;

endpackage

// File: rtl/fpu_cmd_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push while full is accepted
// only when a pop happens in the same cycle.
module fpu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                     (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/fpu_cmd_sequencer.sv
// Front-end for the FPU datapath: buffers requests, issues them one at a time
// with a start pulse and stable operands, and returns result/tag/error.
module fpu_cmd_sequencer
    import fpu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              dp_start,
    output logic [OP_W-1:0]   dp_alu_control,
    output logic [DATA_W-1:0] dp_a,
    output logic [DATA_W-1:0] dp_b,
    input  logic [DATA_W-1:0] dp_result,
    input  logic              dp_done,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_err,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int ENTRY_W = $bits(req_t) + TAG_W;
    localparam int CNT_W   = $clog2(TIMEOUT);

    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic [ENTRY_W-1:0] fifo_rdata;
    req_t               head_req;
    logic [TAG_W-1:0]   head_tag;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dp_start_q, dp_start_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_result_q, rsp_result_d;
    logic               rsp_err_q, rsp_err_d;

    fpu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_valid && !fifo_full),
        .wdata ({req_tag, req_op, req_a, req_b}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign {head_tag, head_req} = fifo_rdata;

    // The counter is zero during ISSUE and equals k in the k-th WAIT cycle,
    // so the timeout fires TIMEOUT cycles after the start pulse.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dp_start_d   = 1'b0;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        tag_d        = tag_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        fifo_pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    op_d       = head_req.op;
                    a_d        = head_req.a;
                    b_d        = head_req.b;
                    tag_d      = head_tag;
                    dp_start_d = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (dp_done) begin
                    rsp_result_d = dp_result;
                    rsp_err_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                    state_d      = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_result_d = '0;
                    rsp_err_d    = 1'b1;
                    rsp_valid_d  = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            dp_start_q   <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            tag_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dp_start_q   <= dp_start_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            tag_q        <= tag_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign req_ready      = !fifo_full;
    assign dp_start       = dp_start_q;
    assign dp_alu_control = op_q;
    assign dp_a           = a_q;
    assign dp_b           = b_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_result     = rsp_result_q;
    assign rsp_tag        = tag_q;
    assign rsp_err        = rsp_err_q;
    assign busy           = (state_q != ST_IDLE) || !fifo_empty;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
// Directed bench for fpu_cmd_sequencer with a scoreboard queue of expected
// responses and a behavioural datapath whose done latency is set per test.
module tb_fpu_cmd_sequencer;

  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 16;
  localparam int EXP_W   = 1 + TAG_W + 32;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [31:0]       req_a;
  logic [31:0]       req_b;
  logic [TAG_W-1:0]  req_tag;
  logic              dp_start;
  logic [1:0]        dp_alu_control;
  logic [31:0]       dp_a;
  logic [31:0]       dp_b;
  logic [31:0]       dp_result;
  logic              dp_done;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_result;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_err;
  logic              busy;
  logic [1:0]        dbg_state;

  logic [EXP_W-1:0]  exp_q[$];
  int                checks;
  int                errors;
  int                cyc;
  int                start_cnt;
  int                start_cyc;
  int                dp_lat;
  int                dp_k;
  logic              dp_act;

  fpu_cmd_sequencer #(
    .DEPTH   (4),
    .TAG_W   (TAG_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_a          (req_a),
    .req_b          (req_b),
    .req_tag        (req_tag),
    .dp_start       (dp_start),
    .dp_alu_control (dp_alu_control),
    .dp_a           (dp_a),
    .dp_b           (dp_b),
    .dp_result      (dp_result),
    .dp_done        (dp_done),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_result     (rsp_result),
    .rsp_tag        (rsp_tag),
    .rsp_err        (rsp_err),
    .busy           (busy),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // behavioural datapath: done is high in the lat-th cycle after the start cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      dp_act    = 1'b0;
      dp_k      = 0;
      dp_done   = 1'b0;
      dp_result = 32'hDEAD_BEEF;
    end else begin
      if (dp_start) begin
        dp_act = 1'b1;
        dp_k   = 0;
        start_cnt++;
        start_cyc = cyc;
      end else if (dp_act) begin
        dp_k++;
      end
      if (dp_act && dp_lat > 0 && dp_k == dp_lat) begin
        dp_done   = 1'b1;
        dp_result = dp_a + dp_b;
        dp_act    = 1'b0;
      end else begin
        dp_done   = 1'b0;
        dp_result = 32'hDEAD_BEEF;
      end
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got tag %0d result %h err %0d, expected no response",
                 rsp_tag, rsp_result, rsp_err);
      end else begin
        check("rsp", 64'({rsp_err, rsp_tag, rsp_result}), 64'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag, input logic err, input logic [31:0] res);
    int   n;
    logic ok;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = req_ready;
      @(posedge clk);
      #1;
      n++;
    end
    req_valid = 1'b0;
    if (ok) exp_q.push_back({err, tag, res});
    else check("push_accept", 64'(ok), 64'd1);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_budget", 64'(exp_q.size()), 64'd0);
    sync();
  endtask

  task automatic wait_rsp_valid(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("rsp_valid_in_budget", 64'(rsp_valid), 64'd1);
  endtask

  initial begin
    int s;
    int sc;
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    start_cnt = 0;
    start_cyc = 0;
    dp_lat    = 5;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_tag   = '0;
    rsp_ready = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_dp_start", 64'(dp_start), 64'd0);
    check("reset_rsp_err", 64'(rsp_err), 64'd0);
    check("reset_dp_regs", 64'({dp_alu_control, dp_a, dp_b}), 64'd0);
    check("reset_rsp_regs", 64'({rsp_result, rsp_tag}), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_req_ready", 64'(req_ready), 64'd1);
    check("post_reset_busy", 64'(busy), 64'd0);
    sync();

    // single op: start pulse two cycles after the push cycle
    dp_lat = 5;
    s = start_cnt;
    push(2'b00, 32'h0001_8000, 32'h0002_0000, 4'd3, 1'b0, 32'h0003_8000);
    @(negedge clk);
    check("single_no_early_start", 64'(dp_start), 64'd0);
    @(negedge clk);
    check("single_start_pulse", 64'(dp_start), 64'd1);
    check("single_operands", 64'({dp_alu_control, dp_a}), 64'({2'b00, 32'h0001_8000}));
    @(negedge clk);
    check("single_start_one_cycle", 64'(dp_start), 64'd0);
    wait_drain(40);
    check("single_start_count", 64'(start_cnt - s), 64'd1);

    // FIFO full: five back-to-back, the sixth must wait
    dp_lat = 12;
    for (int i = 1; i <= 5; i++)
      push(2'(i), 32'(i * 256), 32'(i), 4'(i), 1'b0, 32'(i * 257));
    @(negedge clk);
    check("full_req_ready_low", 64'(req_ready), 64'd0);
    check("full_busy", 64'(busy), 64'd1);
    sync();
    push(2'd2, 32'h0000_0600, 32'h0000_0006, 4'd6, 1'b0, 32'h0000_0606);
    wait_drain(300);

    // backpressure: response held, no new issue
    rsp_ready = 1'b0;
    dp_lat    = 3;
    push(2'b01, 32'h0000_1000, 32'h0000_0234, 4'd9, 1'b0, 32'h0000_1234);
    push(2'b10, 32'h0000_0005, 32'h0000_0006, 4'd10, 1'b0, 32'h0000_000B);
    wait_rsp_valid(40);
    s = start_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_rsp_stable", 64'({rsp_valid, rsp_err, rsp_tag, rsp_result}),
            64'({1'b1, 1'b0, 4'd9, 32'h0000_1234}));
    end
    check("bp_no_second_start", 64'(start_cnt - s), 64'd0);
    sync();
    rsp_ready = 1'b1;
    wait_drain(40);
    check("bp_second_issued", 64'(start_cnt - s), 64'd1);

    // timeout: error response exactly TIMEOUT cycles after start, next one normal
    dp_lat = 0;
    s = start_cnt;
    push(2'b11, 32'h0000_0001, 32'h0000_0002, 4'd5, 1'b1, 32'h0);
    push(2'b00, 32'h0000_000A, 32'h0000_0014, 4'd6, 1'b0, 32'h0000_001E);
    wait_rsp_valid(60);
    check("timeout_latency", 64'(cyc - start_cyc), 64'd16);
    check("timeout_err_result", 64'({rsp_err, rsp_result}), 64'({1'b1, 32'h0}));
    dp_lat = 4;
    wait_drain(60);
    check("timeout_next_issued", 64'(start_cnt - s), 64'd2);

    // done exactly on the timeout boundary wins; one cycle later times out
    dp_lat = 15;
    push(2'b01, 32'h1234_0000, 32'h0000_5678, 4'd7, 1'b0, 32'h1234_5678);
    wait_drain(60);
    dp_lat = 16;
    push(2'b01, 32'h0000_0100, 32'h0000_0200, 4'd8, 1'b1, 32'h0);
    wait_drain(60);

    // reset mid-WAIT aborts silently
    dp_lat = 0;
    push(2'b00, 32'h0000_0011, 32'h0000_0022, 4'd11, 1'b0, 32'h0);
    push(2'b00, 32'h0000_0033, 32'h0000_0044, 4'd12, 1'b0, 32'h0);
    s = 0;
    while (dbg_state != 2'd2 && s < 40) begin
      @(negedge clk);
      s++;
    end
    check("rst_reached_wait", 64'(dbg_state), 64'd2);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_state_idle", 64'(dbg_state), 64'd0);
    sync();
    sync();
    rst_n = 1'b1;
    sc = start_cnt;
    repeat (40) @(negedge clk);
    check("rst_no_reissue", 64'(start_cnt - sc), 64'd0);
    check("rst_idle_after", 64'(busy), 64'd0);
    sync();

    // recovery after reset
    dp_lat = 2;
    push(2'b10, 32'h0000_0F00, 32'h0000_00FF, 4'd13, 1'b0, 32'h0000_0FFF);
    wait_drain(40);

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
